// File: rtl/aes_round_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_engine_pkg
// Brief    : Engine state type, round constants and GF(2^8) helpers for the
//            iterative AES-128 round engine.
// Revision : 1.0 - initial release
// ============================================================================
package aes_round_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READY  = 2'd1,
        ST_ROUND  = 2'd2,
        ST_OUTPUT = 2'd3
    } aes_engine_state_t;

    localparam logic [3:0] AES_N_ROUNDS = 4'd10;

    localparam logic [7:0] AES_RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Only the MixColumns coefficients 1, 2 and 3 are ever needed.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [1:0] m);
        logic [7:0] p;
        case (m)
            2'd1:    p = a;
            2'd2:    p = xtime(a);
            2'd3:    p = xtime(a) ^ a;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox
// Brief    : Combinational AES forward S-box, 8-bit in to 8-bit out.
// Revision : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so entry d has its MSB at 8*(255-d)+7.
    assign data_o = SBOX_TABLE[{~data_i, 3'b111} -: 8];

endmodule
`default_nettype wire

// File: rtl/aes_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_engine
// Brief    : Iterative AES-128 encryptor, one round per cycle with on-the-fly
//            key expansion. Define AES_BLOCK_CNT_EN to enable blk_cnt_o.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_engine
    import aes_round_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int N_ROUNDS   = 10,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH-1:0] key_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  blk_cnt_o
);

    localparam logic [3:0] LAST_RND = 4'(N_ROUNDS);

    aes_engine_state_t     state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic [DATA_WIDTH-1:0] rk_q, rk_d;
    logic [3:0]            rnd_q, rnd_d;

    logic [DATA_WIDTH-1:0] w_sb, w_sr, w_mc, w_rk_next, w_round_out;
    logic [31:0]           w_rot, w_subword, w_temp;
    logic [31:0]           w_n0, w_n1, w_n2, w_n3;
    logic [7:0]            w_rcon;
    logic                  w_rnd_ok;

    assign w_rnd_ok = (rnd_q != 4'd0) && (rnd_q <= AES_N_ROUNDS);
    assign w_rcon   = w_rnd_ok ? AES_RCON[rnd_q - 4'd1] : 8'h00;

    // Round datapath: SubBytes -> ShiftRows -> MixColumns, column-major bytes
    for (genvar i = 0; i < 16; i++) begin : g_subbytes
        aes_sbox u_sbox (
            .data_i (data_q[127-8*i -: 8]),
            .data_o (w_sb[127-8*i -: 8])
        );
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
        end
        assign w_a0 = w_sr[127-32*c -: 8];
        assign w_a1 = w_sr[119-32*c -: 8];
        assign w_a2 = w_sr[111-32*c -: 8];
        assign w_a3 = w_sr[103-32*c -: 8];
        assign w_mc[127-32*c -: 8] = gmul(w_a0, 2'd2) ^ gmul(w_a1, 2'd3) ^ w_a2 ^ w_a3;
        assign w_mc[119-32*c -: 8] = w_a0 ^ gmul(w_a1, 2'd2) ^ gmul(w_a2, 2'd3) ^ w_a3;
        assign w_mc[111-32*c -: 8] = w_a0 ^ w_a1 ^ gmul(w_a2, 2'd2) ^ gmul(w_a3, 2'd3);
        assign w_mc[103-32*c -: 8] = gmul(w_a0, 2'd3) ^ w_a1 ^ w_a2 ^ gmul(w_a3, 2'd2);
    end

    // Key expansion: next round key derived from the current one each round
    assign w_rot = {rk_q[23:0], rk_q[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .data_i (w_rot[31-8*i -: 8]),
            .data_o (w_subword[31-8*i -: 8])
        );
    end

    assign w_temp    = w_subword ^ {w_rcon, 24'h000000};
    assign w_n0      = rk_q[127:96] ^ w_temp;
    assign w_n1      = rk_q[95:64]  ^ w_n0;
    assign w_n2      = rk_q[63:32]  ^ w_n1;
    assign w_n3      = rk_q[31:0]   ^ w_n2;
    assign w_rk_next = {w_n0, w_n1, w_n2, w_n3};

    assign w_round_out = ((rnd_q == LAST_RND) ? w_sr : w_mc) ^ w_rk_next;

    always_ff @(posedge clk) begin
        if (!reset_n || clear_i) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            key_q   <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        if (enable_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        key_d   = key_i;
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    if (in_valid_i) begin
                        data_d  = in_data_i ^ key_q;
                        rk_d    = key_q;
                        rnd_d   = 4'd1;
                        state_d = ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (!w_rnd_ok) begin
                        state_d = ST_IDLE;
                    end else begin
                        data_d = w_round_out;
                        rk_d   = w_rk_next;
                        rnd_d  = rnd_q + 4'd1;
                        if (rnd_q == LAST_RND) begin
                            state_d = ST_OUTPUT;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready_i) begin
                        state_d = ST_READY;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign in_ready_o  = enable_i && (state_q == ST_READY);
    assign out_valid_o = enable_i && (state_q == ST_OUTPUT);
    assign out_data_o  = (state_q == ST_OUTPUT) ? data_q : '0;
    assign busy_o      = (state_q == ST_ROUND) || (state_q == ST_OUTPUT);
    assign done_o      = out_valid_o && out_ready_i;

`ifdef AES_BLOCK_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n || clear_i) begin
            cnt_q <= '0;
        end else if (done_o) begin
            cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign blk_cnt_o = cnt_q;
`else
    assign blk_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_round_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_engine
// Brief    : Scoreboard bench for aes_round_engine against a byte-level AES model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_engine;

`ifdef AES_BLOCK_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clear_i = 1'b0;
    logic         start_i = 1'b0;
    logic         enable_i = 1'b0;
    logic [127:0] key_i = '0;
    logic [127:0] in_data_i = '0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [127:0] out_data_o;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic         busy_o;
    logic         done_o;
    logic [31:0]  blk_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   sbox_t [256];

    aes_round_engine dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .enable_i    (enable_i),
        .key_i       (key_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .blk_cnt_o   (blk_cnt_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from the multiplicative inverse plus the affine transform
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] coef [4];
        logic [7:0] rc;
        logic [7:0] x;
        logic [127:0] res;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                x = tmp[0];
                for (int j = 0; j < 3; j++) tmp[j] = sbox_t[tmp[j+1]];
                tmp[3] = sbox_t[x];
                tmp[0] = tmp[0] ^ rc;
                rc = gf_mul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = sbox_t[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rnd == 10) s[4*c+r] = t[4*c+r];
                    else begin
                        x = 8'h00;
                        for (int k = 0; k < 4; k++)
                            x = x ^ gf_mul(coef[(k-r+4)%4], t[4*c+k]);
                        s[4*c+r] = x;
                    end
                end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic do_start(input logic [127:0] key);
        key_i   = key;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        key_i   = rand128();
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] key);
        in_data_i  = pt;
        in_valid_i = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready_o) begin
                exp_q.push_back(aes_ref(key, pt));
                tick();
                in_valid_i = 1'b0;
                in_data_i  = rand128();
                return;
            end
        end
        in_valid_i = 1'b0;
        errors++;
        $display("FAIL input_handshake: got timeout expected in_ready_o");
    endtask

    task automatic wait_valid(output int cyc, output logic rdy_seen);
        cyc = 0;
        rdy_seen = 1'b0;
        while (cyc < 200) begin
            if (out_valid_o) return;
            if (in_ready_o) rdy_seen = 1'b1;
            tick();
            cyc++;
        end
        errors++;
        $display("FAIL output_wait: got timeout expected out_valid_o");
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (done_o !== (out_valid_o && out_ready_i)) begin
            errors++;
            $display("FAIL done_pulse: got %b expected %b", done_o, out_valid_o && out_ready_i);
        end
        if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h expected none", out_data_o);
            end else begin
                check("ciphertext", out_data_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int total;
        logic rdy;
        logic [127:0] k, pt, e;

        build_sbox();
        enable_i = 1'b1;
        repeat (2) tick();
        check("reset_outputs",
              {out_data_o, in_ready_o, out_valid_o, busy_o, done_o},
              '0);
        check("reset_blk_cnt", 128'(blk_cnt_o), 128'd0);
        reset_n = 1'b1;
        out_ready_i = 1'b1;
        tick();

        // FIPS-197 C.1
        do_start(K1);
        send(P1, K1);
        wait_valid(cyc, rdy);
        check("c1_latency", 128'(cyc), 128'd10);
        check("c1_data", out_data_o, C1);
        check("c1_in_ready_in_round", 128'(rdy), 128'd0);
        tick();
        check("c1_done_one_cycle", 128'(done_o), 128'd0);
        check("c1_back_to_ready", {126'd0, busy_o, in_ready_o}, 128'd1);

        // Appendix B, back-to-back without a new start
        do_clear();
        do_start(KB);
        for (int b = 0; b < 2; b++) begin
            send(PB, KB);
            wait_valid(cyc, rdy);
            check("b_data", out_data_o, CB);
            check("b_in_ready_in_round", 128'(rdy), 128'd0);
            tick();
        end

        // Output backpressure
        out_ready_i = 1'b0;
        pt = rand128();
        e  = aes_ref(KB, pt);
        send(pt, KB);
        wait_valid(cyc, rdy);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 128'(out_valid_o), 128'd1);
            check("bp_data", out_data_o, e);
            check("bp_in_ready", 128'(in_ready_o), 128'd0);
            check("bp_done", 128'(done_o), 128'd0);
            tick();
        end
        out_ready_i = 1'b1;
        tick();

        // Enable stall at rnd == 4
        k = rand128();
        do_clear();
        do_start(k);
        send(rand128(), k);
        repeat (3) tick();
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_no_handshake", {126'd0, in_ready_o, out_valid_o}, 128'd0);
            tick();
        end
        enable_i = 1'b1;
        wait_valid(cyc, rdy);
        total = 6 + cyc;
        check("stall_latency", 128'(total), 128'd13);
        tick();

        // Clear at rnd == 6
        do_clear();
        do_start(k);
        send(rand128(), k);
        repeat (5) tick();
        do_clear();
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        check("clear_outputs",
              {out_data_o, in_ready_o, out_valid_o, busy_o, done_o},
              '0);
        check("clear_blk_cnt", 128'(blk_cnt_o), 128'd0);
        do_start(K1);
        send(P1, K1);
        wait_valid(cyc, rdy);
        check("clear_c1_data", out_data_o, C1);
        tick();

        // Randomized keys, blocks, stalls and backpressure
        for (int n = 0; n < 6; n++) begin
            k = rand128();
            do_clear();
            do_start(k);
            send(rand128(), k);
            repeat ($urandom_range(0, 9)) tick();
            enable_i = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            enable_i = 1'b1;
            out_ready_i = 1'b0;
            wait_valid(cyc, rdy);
            check("rand_in_ready_in_round", 128'(rdy), 128'd0);
            repeat ($urandom_range(0, 3)) tick();
            out_ready_i = 1'b1;
            tick();
        end

        // Block counter, then synchronous reset
        do_clear();
        do_start(KB);
        for (int b = 0; b < 3; b++) begin
            send(rand128(), KB);
            wait_valid(cyc, rdy);
            tick();
        end
        check("cnt_three", 128'(blk_cnt_o), CNT_ON ? 128'd3 : 128'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check("cnt_before_edge", 128'(blk_cnt_o), CNT_ON ? 128'd3 : 128'd0);
        @(posedge clk);
        #1;
        check("cnt_after_reset", 128'(blk_cnt_o), 128'd0);
        check("reset_in_ready", 128'(in_ready_o), 128'd0);
        reset_n = 1'b1;
        tick();

        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
